// File: rtl/pe_seq_ctrl.sv
// Sequencer for one PE: streams operands from the activation/filter buffers,
// captures each finished pe_out and hands it off over a valid/ready port.
module pe_seq_ctrl #(
    parameter int KSIZE   = 9,
    parameter int NUM_OUT = 4,
    parameter int ACC_LAT = 1,
    parameter int AW      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op,
    input  logic [7:0]    cfg_bias,
    output logic          busy,
    output logic          done,
    output logic          ifm_rd_en,
    output logic [AW-1:0] ifm_addr,
    input  logic [7:0]    ifm_data,
    output logic          flt_rd_en,
    output logic [AW-1:0] flt_addr,
    input  logic [7:0]    flt_data,
    output logic [7:0]    pe_in,
    output logic [7:0]    pe_filter,
    output logic [1:0]    pe_mode,
    output logic          pe_act,
    input  logic [7:0]    pe_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_data,
    output logic [AW-1:0] res_idx
);

    localparam int KW = $clog2(KSIZE + ACC_LAT + 2);
    localparam logic [KW-1:0] K_LAST   = KW'(KSIZE - 1);
    localparam logic [KW-1:0] FL_LAST0 = KW'(ACC_LAT);
    localparam logic [KW-1:0] FL_LAST1 = KW'(1);
    localparam logic [AW-1:0] O_LAST   = AW'(NUM_OUT - 1);

    typedef enum logic [2:0] {IDLE, LOADW, ISSUE, FLUSH, WAITR, DONE} state_t;

    state_t        state, next_state;
    logic [AW-1:0] o;
    logic [KW-1:0] k;
    logic          op_q;
    logic [7:0]    bias_q;
    logic          ifm_q, flt_q, bias_sel_q;
    logic [1:0]    mode_nxt;
    logic          bias_nxt;
    logic          flush_last;
    logic          xfer;

    assign xfer       = res_valid && res_ready;
    assign flush_last = (state == FLUSH) && (k == (op_q ? FL_LAST1 : FL_LAST0));

    // Operands are the buffer outputs, zeroed whenever no read was issued last cycle
    assign pe_in     = ifm_q ? ifm_data : 8'd0;
    assign pe_filter = bias_sel_q ? bias_q : (flt_q ? flt_data : 8'd0);

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        ifm_rd_en  = 1'b0;
        flt_rd_en  = 1'b0;
        ifm_addr   = '0;
        flt_addr   = '0;
        mode_nxt   = 2'd3;
        bias_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = op ? LOADW : ISSUE;
            end
            LOADW: begin
                busy       = 1'b1;
                flt_rd_en  = 1'b1;
                mode_nxt   = 2'd2;
                next_state = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                mode_nxt  = {1'b0, op_q};
                ifm_rd_en = 1'b1;
                if (op_q) begin
                    ifm_addr   = o;
                    bias_nxt   = 1'b1;
                    next_state = FLUSH;
                end else begin
                    flt_rd_en = 1'b1;
                    ifm_addr  = o + AW'(k);
                    flt_addr  = AW'(k);
                    if (k == K_LAST) next_state = FLUSH;
                end
            end
            FLUSH: begin
                busy     = 1'b1;
                mode_nxt = {1'b0, op_q};
                if (flush_last) next_state = WAITR;
            end
            WAITR: begin
                busy     = 1'b1;
                mode_nxt = {1'b0, op_q};
                if (xfer) next_state = (o == O_LAST) ? DONE : ISSUE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // The PE is parked in its idle mode as soon as the job is finishing
        if (next_state == DONE || next_state == IDLE) mode_nxt = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            o          <= '0;
            k          <= '0;
            op_q       <= 1'b0;
            bias_q     <= 8'd0;
            ifm_q      <= 1'b0;
            flt_q      <= 1'b0;
            bias_sel_q <= 1'b0;
            pe_mode    <= 2'd3;
            pe_act     <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= 8'd0;
            res_idx    <= '0;
        end else begin
            state      <= next_state;
            pe_mode    <= mode_nxt;
            pe_act     <= ifm_rd_en | flt_rd_en;
            ifm_q      <= ifm_rd_en;
            flt_q      <= flt_rd_en;
            bias_sel_q <= bias_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        bias_q <= cfg_bias;
                        o      <= '0;
                        k      <= '0;
                    end
                end
                ISSUE: begin
                    if (!op_q) k <= (k == K_LAST) ? '0 : k + 1'b1;
                end
                FLUSH: begin
                    if (flush_last) begin
                        k         <= '0;
                        res_valid <= 1'b1;
                        res_data  <= pe_out;
                        res_idx   <= o;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                WAITR: begin
                    if (xfer) begin
                        res_valid <= 1'b0;
                        if (o != O_LAST) o <= o + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with behavioural buffers and PE; vectors are
// whole jobs with hand-computed results, plus reset and backpressure sequences.
module tb_pe_seq_ctrl;

    localparam int KSIZE   = 9;
    localparam int NUM_OUT = 4;
    localparam int AW      = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [7:0]    cfg_bias = 8'd0;
    logic          busy, done;
    logic          ifm_rd_en, flt_rd_en;
    logic [AW-1:0] ifm_addr, flt_addr;
    logic [7:0]    ifm_data = 8'd0;
    logic [7:0]    flt_data = 8'd0;
    logic [7:0]    pe_in, pe_filter;
    logic [1:0]    pe_mode;
    logic          pe_act;
    logic [7:0]    pe_out = 8'd0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [7:0]    res_data;
    logic [AW-1:0] res_idx;

    pe_seq_ctrl #(.KSIZE(KSIZE), .NUM_OUT(NUM_OUT), .ACC_LAT(1), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cfg_bias(cfg_bias),
        .busy(busy), .done(done),
        .ifm_rd_en(ifm_rd_en), .ifm_addr(ifm_addr), .ifm_data(ifm_data),
        .flt_rd_en(flt_rd_en), .flt_addr(flt_addr), .flt_data(flt_data),
        .pe_in(pe_in), .pe_filter(pe_filter), .pe_mode(pe_mode), .pe_act(pe_act),
        .pe_out(pe_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    logic [7:0] ifm_mem [64];
    logic [7:0] flt_mem [64];
    logic [7:0] pe_acc = 8'd0;
    logic [7:0] pe_weight = 8'd0;
    int         pe_tap = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         mode2_cnt = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifm_rd_en) ifm_data <= ifm_mem[ifm_addr];
        if (flt_rd_en) flt_data <= flt_mem[flt_addr];
    end

    // PE: mode 0 accumulates and self-clears after KSIZE taps, 1 is w*x+b, 2 loads w, 3 idles
    always @(posedge clk) begin
        case (pe_mode)
            2'd0: if (pe_act) begin
                if (pe_tap == KSIZE - 1) begin
                    pe_out <= pe_acc + pe_in * pe_filter;
                    pe_acc <= 8'd0;
                    pe_tap <= 0;
                end else begin
                    pe_acc <= pe_acc + pe_in * pe_filter;
                    pe_tap <= pe_tap + 1;
                end
            end
            2'd1: if (pe_act) pe_out <= pe_weight * pe_in + pe_filter;
            2'd2: if (pe_act) pe_weight <= pe_filter;
            default: begin
                pe_acc <= 8'd0;
                pe_tap <= 0;
            end
        endcase
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (pe_mode == 2'd2) mode2_cnt <= mode2_cnt + 1;
    end

    typedef struct {
        logic            op;
        logic [7:0]      bias;
        logic [7:0]      ifm_start;
        logic [7:0]      ifm_step;
        logic [7:0]      flt_val;
        int              hold;
        logic            ghost;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic o, input logic [7:0] b, input logic [7:0] s,
                                input logic [7:0] st, input logic [7:0] f, input int h,
                                input logic g, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        vec_t v;
        v.op = o; v.bias = b; v.ifm_start = s; v.ifm_step = st; v.flt_val = f;
        v.hold = h; v.ghost = g; v.exp = {e3, e2, e1, e0};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic loadBuffers(input vec_t v);
        for (int i = 0; i < 64; i++) begin
            ifm_mem[i] = v.ifm_start + 8'(i) * v.ifm_step;
            flt_mem[i] = v.flt_val;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pe_mode"}, pe_mode, 2'd3);
        checkOutput({tag, "_outputs"},
                    {busy, done, ifm_rd_en, ifm_addr, flt_rd_en, flt_addr, pe_in,
                     pe_filter, pe_act, res_valid, res_data, res_idx}, 64'd0);
    endtask

    // Runs one complete job and checks every result, its timing and the job wrap-up
    task automatic applyStimulus(input vec_t v);
        int last, gap, dn0, m20;
        loadBuffers(v);
        dn0 = done_cnt;
        m20 = mode2_cnt;
        @(negedge clk);
        start = 1'b1; op = v.op; cfg_bias = v.bias; res_ready = 1'b1;
        last = cyc;
        @(negedge clk);
        start = 1'b0; op = ~v.op; cfg_bias = 8'hA5;
        for (int r = 0; r < NUM_OUT; r++) begin
            for (int c = 0; c < 200 && !res_valid; c++) @(negedge clk);
            if (!res_valid) begin
                checkOutput("res_valid_timeout", 0, 1);
                return;
            end
            if (r == 0) gap = v.op ? 5 : 12;
            else gap = (v.op ? 4 : 12) + ((r == 2) ? v.hold : 0);
            checkOutput($sformatf("latency_r%0d", r), cyc - last, gap);
            last = cyc;
            checkOutput($sformatf("res_data_r%0d", r), res_data, v.exp[r]);
            checkOutput($sformatf("res_idx_r%0d", r), res_idx, r);
            if (r == 1 && v.hold > 0) begin
                for (int h = 0; h < v.hold; h++) begin
                    checkOutput($sformatf("hold_c%0d", h),
                                {res_valid, res_data, res_idx, ifm_rd_en, flt_rd_en, pe_act},
                                {1'b1, v.exp[1], 6'd1, 3'b000});
                    @(negedge clk);
                end
                res_ready = 1'b1;
            end
            @(negedge clk);
            if (r == 0 && v.hold > 0) res_ready = 1'b0;
            if (r == 0 && v.ghost) begin
                start = 1'b1; op = ~v.op;
                @(negedge clk);
                start = 1'b0;
            end
        end
        for (int c = 0; c < 50 && !done; c++) @(negedge clk);
        checkOutput("done_seen", done, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy_after", busy, 0);
        checkOutput("done_pulses", done_cnt - dn0, 1);
        checkOutput("mode2_cycles", mode2_cnt - m20, v.op ? 1 : 0);
    endtask

    initial begin
        int s;
        vecs[0] = mk(1'b0, 8'd0,   8'd1,   8'd1, 8'd1,  0, 1'b0, 8'd45,  8'd54,  8'd63,  8'd72);
        vecs[1] = mk(1'b0, 8'd0,   8'd16,  8'd0, 8'd2,  0, 1'b0, 8'd32,  8'd32,  8'd32,  8'd32);
        vecs[2] = mk(1'b1, 8'd5,   8'd1,   8'd1, 8'd3,  0, 1'b0, 8'd8,   8'd11,  8'd14,  8'd17);
        vecs[3] = mk(1'b0, 8'd0,   8'd1,   8'd1, 8'd1,  5, 1'b0, 8'd45,  8'd54,  8'd63,  8'd72);
        vecs[4] = mk(1'b0, 8'd0,   8'd1,   8'd1, 8'd1,  0, 1'b1, 8'd45,  8'd54,  8'd63,  8'd72);
        vecs[5] = mk(1'b0, 8'd0,   8'd250, 8'd1, 8'd1,  0, 1'b0, 8'd238, 8'd247, 8'd0,   8'd9);
        vecs[6] = mk(1'b1, 8'd250, 8'd30,  8'd1, 8'd10, 0, 1'b0, 8'd38,  8'd48,  8'd58,  8'd68);

        repeat (3) @(negedge clk);
        checkResetValues("reset_held");
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("reset_idle");

        for (int i = 0; i < 7; i++) begin
            $display("[TB] job vector %0d", i);
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset in the middle of a convolution");
        loadBuffers(vecs[0]);
        @(negedge clk);
        start = 1'b1; op = 1'b0;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid_job_cycle", cyc - s, 5);
        checkOutput("ifm_addr_k4", ifm_addr, 4);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("reset_mid_job");
        rst = 1'b0;
        applyStimulus(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
